// File: rtl/riscv_imm_pkg.sv
// riscv_imm_pkg: RV32I opcodes and immediate-format encoding shared by the immediate generator
package riscv_imm_pkg;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;
endpackage

// File: rtl/riscv_imm_decode.sv
// riscv_imm_decode: opcode classification and sign-extended immediate assembly (combinational)
module riscv_imm_decode
    import riscv_imm_pkg::*;
(
    input  logic [31:0] instruction,
    output logic [31:0] imm,
    output imm_type_e   imm_type,
    output logic        illegal
);
    logic [6:0]  opc;
    logic [31:0] ins;

    assign opc = instruction[6:0];
    assign ins = instruction;

    // Map the opcode to an immediate format; anything outside RV32I is flagged illegal
    always_comb begin
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_FENCE, OPC_SYSTEM: imm_type = IMM_I;
            OPC_STORE:            imm_type = IMM_S;
            OPC_BRANCH:           imm_type = IMM_B;
            OPC_LUI, OPC_AUIPC:   imm_type = IMM_U;
            OPC_JAL:              imm_type = IMM_J;
            OPC_OP:               imm_type = IMM_NONE;
            default:              illegal  = 1'b1;
        endcase
    end

    // Gather the scattered immediate fields; the sign always comes from bit 31
    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm = {ins[31:12], 12'b0};
            IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = '0;
        endcase
    end
endmodule

// File: rtl/riscv_imm_gen.sv
// riscv_imm_gen: RV32I immediate generator with optional output register and valid pipe
module riscv_imm_gen
    import riscv_imm_pkg::*;
#(
    parameter int REG_OUT = 1,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [31:0]     instruction,
    output logic            out_valid,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      imm_type,
    output logic            illegal
);
    logic [31:0] dec_imm;
    imm_type_e   dec_type;
    logic        dec_ill;

    riscv_imm_decode u_decode (
        .instruction (instruction),
        .imm         (dec_imm),
        .imm_type    (dec_type),
        .illegal     (dec_ill)
    );

    generate
        if (REG_OUT != 0) begin : g_reg
            // Results load only on qualified cycles so idle (possibly unknown) words never reach the holds
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    imm       <= '0;
                    imm_type  <= IMM_NONE;
                    illegal   <= 1'b0;
                end else begin
                    out_valid <= in_valid;
                    if (in_valid) begin
                        imm      <= dec_imm;
                        imm_type <= dec_type;
                        illegal  <= dec_ill;
                    end
                end
            end
        end else begin : g_comb
            logic unused_clk;
            assign unused_clk = clk ^ rst_n;
            assign out_valid  = in_valid;
            assign imm        = dec_imm;
            assign imm_type   = dec_type;
            assign illegal    = dec_ill;
        end
    endgenerate
endmodule

// File: tb/tb_riscv_imm_gen.sv
// tb_riscv_imm_gen: scoreboard bench with directed vectors and randomized instructions against a reference model
module tb_riscv_imm_gen;
    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  t;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instruction;
    logic        out_valid;
    logic [31:0] imm;
    logic [2:0]  imm_type;
    logic        illegal;

    int passed = 0;
    int total  = 0;
    exp_t sbq[$];

    riscv_imm_gen #(.REG_OUT(1), .XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .instruction (instruction),
        .out_valid   (out_valid),
        .imm         (imm),
        .imm_type    (imm_type),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: immediate value built from weighted fields with signed arithmetic
    function automatic exp_t model(input logic [31:0] ins);
        exp_t e;
        longint v;
        longint sg;
        e  = '0;
        v  = 0;
        sg = ins[31] ? 1 : 0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: begin
                e.t = 3'd1;
                v = longint'(ins[31:20]) - sg * 4096;
            end
            7'h23: begin
                e.t = 3'd2;
                v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]) - sg * 4096;
            end
            7'h63: begin
                e.t = 3'd3;
                v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2 - sg * 4096;
            end
            7'h37, 7'h17: begin
                e.t = 3'd4;
                v = longint'(ins[31:12]) * 4096;
            end
            7'h6F: begin
                e.t = 3'd5;
                v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2 - sg * 1048576;
            end
            7'h33: e.t = 3'd0;
            default: e.ill = 1'b1;
        endcase
        e.imm = v[31:0];
        return e;
    endfunction

    task automatic send(input logic [31:0] ins, input exp_t e);
        @(negedge clk);
        in_valid    = 1'b1;
        instruction = ins;
        sbq.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid    = 1'b0;
        instruction = $urandom;
    endtask

    // Monitor: every presented result is matched against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sbq.size() == 0) chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            else begin
                exp_t e;
                e = sbq.pop_front();
                chk("result", 64'({imm, imm_type, illegal}), 64'(e));
            end
        end
    end

    logic [31:0] dir_ins [12];
    logic [31:0] dir_imm [12];
    logic [2:0]  dir_typ [12];
    logic        dir_ill [12];
    logic [6:0]  opcs    [12];

    initial begin
        dir_ins = '{32'h00100003, 32'h00110013, 32'hFFF00013, 32'hFFFFFFA3, 32'h00A02423, 32'hC0151063,
                    32'h00000463, 32'h12345037, 32'h0080006F, 32'h0000007F, 32'h00B50533, 32'hFFDFF06F};
        dir_imm = '{32'h00000001, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000008, 32'hFFFFF400,
                    32'h00000008, 32'h12345000, 32'h00000008, 32'h00000000, 32'h00000000, 32'hFFFFFFFC};
        dir_typ = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd0, 3'd0, 3'd5};
        dir_ill = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        opcs    = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        instruction = 32'h0;
        #3;
        chk("reset_state", 64'({out_valid, imm, imm_type, illegal}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("idle_after_reset", 64'(out_valid), 64'd0);

        for (int i = 0; i < 12; i++) send(dir_ins[i], '{dir_imm[i], dir_typ[i], dir_ill[i]});
        idle();
        @(posedge clk);
        #1;
        chk("hold_valid", 64'(out_valid), 64'd0);
        chk("hold_imm", 64'({imm, imm_type, illegal}), 64'({32'hFFFFFFFC, 3'd5, 1'b0}));
        idle();
        @(posedge clk);
        #1 chk("hold_imm_2", 64'({imm, imm_type, illegal}), 64'({32'hFFFFFFFC, 3'd5, 1'b0}));

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else begin
                logic [31:0] r;
                r = $urandom;
                if ($urandom_range(0, 9) != 0) r[6:0] = opcs[$urandom_range(0, 11)];
                send(r, model(r));
            end
        end
        idle();
        idle();

        @(negedge clk);
        in_valid    = 1'b1;
        instruction = 32'h00100003;
        @(posedge clk);
        #1 chk("inflight_valid", 64'(out_valid), 64'd1);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1 chk("async_reset", 64'({out_valid, imm, imm_type, illegal}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("post_reset_idle", 64'(out_valid), 64'd0);
        send(32'h12345037, '{32'h12345000, 3'd4, 1'b0});
        idle();

        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        chk("drain", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/riscv_imm_gen.md
Name: riscv_imm_gen

Overview:
RV32I immediate generator for the decode stage. Decodes the 7-bit opcode of a 32-bit instruction, selects the immediate format (I/S/B/U/J), and assembles and sign-extends the immediate to 32 bits. Output is registered by default, with a valid strobe and an illegal-opcode flag, and feeds the ALU operand mux and the branch/jump target adder.

Parameters:
- REG_OUT, default 1: 1 = outputs registered (1-cycle latency); 0 = purely combinational path, clk/rst_n unused.
- XLEN, default 32: output width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  instruction qualifier
- instruction  in  32  raw instruction word
- out_valid  out  1  imm/imm_type/illegal valid
- imm  out  32  sign-extended immediate
- imm_type  out  3  format: 0=NONE, 1=I, 2=S, 3=B, 4=U, 5=J
- illegal  out  1  opcode not in the RV32I base set

Behaviour:
- Opcode = instruction[6:0]. Format mapping:
  - I-type: 0000011 LOAD, 0010011 OP-IMM, 1100111 JALR, 0001111 FENCE, 1110011 SYSTEM.
  - S-type: 0100011 STORE.
  - B-type: 1100011 BRANCH.
  - U-type: 0110111 LUI, 0010111 AUIPC.
  - J-type: 1101111 JAL.
  - NONE: 0110011 OP; imm=0, illegal=0.
  - Any other opcode: imm=0, imm_type=NONE, illegal=1.
- Immediate assembly (ins = instruction):
  - I: sext(ins[31:20]).
  - S: sext({ins[31:25], ins[11:7]}).
  - B: sext({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}). Bit 0 is always 0.
  - U: {ins[31:12], 12'b0}.
  - J: sext({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}). Bit 0 is always 0.
- Sign bit is always ins[31]. funct3/funct7 are ignored. For SLLI/SRLI/SRAI the full I immediate, including funct7 bits, is output unchanged.
- REG_OUT=1:
  - imm, imm_type and illegal load on a rising clk edge when in_valid=1, and hold otherwise.
  - out_valid <= in_valid every cycle.
  - Latency is exactly 1 cycle. Back-to-back valid inputs give back-to-back outputs. There is no backpressure.
- Reset (rst_n=0, asynchronous): imm=0, imm_type=NONE, illegal=0, out_valid=0, immediately without a clock edge. Asserting reset mid-stream discards the in-flight result. First output after release comes 1 cycle after the first in_valid sampled high.
- REG_OUT=0: outputs equal the combinational decode of the current instruction; out_valid = in_valid.
- X/unknown opcode bits must not propagate into the held registers while in_valid=0.

Decomposition:
- Package riscv_imm_pkg:
  - opcode localparams (OPC_LOAD, OPC_OP_IMM, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_FENCE, OPC_SYSTEM, OPC_OP);
  - enum imm_type_e {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} as logic [2:0].
- One combinational sub-module, riscv_imm_decode (instruction -> imm, imm_type, illegal). The top adds the optional register stage and valid pipe.

Test Plan:
- Load/OP-IMM: 0x00100003, then 0x00110013, in_valid=1 -> one cycle later imm=0x00000001, imm_type=I for both; 0xFFF00013 -> imm=0xFFFFFFFF.
- Store: 0xFFFFFFA3 -> imm=0xFFFFFFFF, imm_type=S; 0x00A02423 (sw x10,8(x0)) -> imm=0x00000008.
- Branch: 0xC0151063 -> imm=0xFFFFF400 (-3072), imm_type=B, bit0=0; 0x00000463 -> imm=0x00000008.
- U/J: 0x12345037 (LUI) -> imm=0x12345000, type U; 0x0080006F (JAL +8) -> imm=0x00000008, type J; 0xFFDFF06F -> imm=0xFFFFFFFC.
- Illegal/NONE: 0x0000007F -> imm=0, type NONE, illegal=1; 0x00B50533 (add) -> imm=0, illegal=0.
- Reset/valid: assert rst_n=0 between clock edges -> all outputs 0 immediately. With in_valid=0 after a valid load -> out_valid=0, imm holds its last value. Back-to-back streaming of 4 instructions -> 4 consecutive out_valid cycles in order.
